// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// data load/store. A four-state FSM (IDLE, ISSUE, WAIT, DONE) serialises
// the requesters. Data is given priority over fetch, and a store wins over
// a load. Read data and a one-cycle ready pulse go back to the granted side.
//
// Handshake: a requester holds its req level until its ready pulse. It must
// drop req before the clock edge that ends the DONE cycle. The memory takes
// a one-cycle ren/wen strobe and raises bus_busy while it works. Read data
// is taken on the first WAIT edge where bus_busy is low.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read_req,
  input  logic              d_write_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_sel,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_sel,
  output logic              bus_ren,
  output logic              bus_wen,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_busy,
  output logic              stall,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             grant_data;   // 1: data side owns the access, 0: fetch
  logic             grant_write;  // 1: granted data access is a store
  logic [CNT_W-1:0] timeout_cnt;

  // Freeze the core while any request is pending, released in the ready cycle
  assign stall = (i_read_req | d_read_req | d_write_req) & ~(i_ready | d_ready);

  // Arbitration FSM with registered bus, ready and read-data outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_data  <= 1'b0;
      grant_write <= 1'b0;
      timeout_cnt <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      i_ready     <= 1'b0;
      d_ready     <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_sel     <= 4'h0;
      bus_ren     <= 1'b0;
      bus_wen     <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_write_req || d_read_req) begin
            // Data first: the current instruction finishes before next fetch
            grant_data  <= 1'b1;
            grant_write <= d_write_req;
            bus_addr    <= d_addr;
            bus_wdata   <= d_wdata;
            bus_sel     <= d_sel;
            bus_wen     <= d_write_req;
            bus_ren     <= ~d_write_req;
            state       <= ISSUE;
          end else if (i_read_req) begin
            grant_data  <= 1'b0;
            grant_write <= 1'b0;
            bus_addr    <= i_addr;
            bus_wdata   <= '0;
            bus_sel     <= 4'hF;
            bus_ren     <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          bus_ren <= 1'b0;
          bus_wen <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (!bus_busy) begin
            if (grant_data) begin
              if (!grant_write) d_rdata <= bus_rdata;
              d_ready <= 1'b1;
            end else begin
              i_rdata <= bus_rdata;
              i_ready <= 1'b1;
            end
            state <= DONE;
          end else if (timeout_cnt == CNT_LAST) begin
            // Memory never answered: abort with zero data and flag it
            bus_err <= 1'b1;
            if (grant_data) begin
              d_rdata <= '0;
              d_ready <= 1'b1;
            end else begin
              i_rdata <= '0;
              i_ready <= 1'b1;
            end
            state <= DONE;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        DONE: begin
          i_ready     <= 1'b0;
          d_ready     <= 1'b0;
          timeout_cnt <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch and data load/store.
- Serialises the two requesters through an issue/wait handshake with the memory.
- Returns read data and a one-cycle ready pulse to the winning requester.
- Drives a stall to freeze the PC and datapath while any access is outstanding. Sits between the core top and the memory/bus model.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, maximum cycles bus_busy may stay high in WAIT before the access is aborted (≥2)

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- i_read_req  in  1  fetch request, level, held until i_ready
- i_addr  in  ADDR_W  fetch address (PC)
- i_rdata  out  DATA_W  fetched instruction, valid while i_ready
- i_ready  out  1  one-cycle completion pulse to fetch
- d_read_req  in  1  load request, level
- d_write_req  in  1  store request, level
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_sel  in  4  byte enables
- d_rdata  out  DATA_W  load data, valid while d_ready
- d_ready  out  1  one-cycle completion pulse to data side
- bus_addr  out  ADDR_W  memory address
- bus_wdata  out  DATA_W  memory write data
- bus_sel  out  4  memory byte enables (4'hF for fetch)
- bus_ren  out  1  read strobe, one cycle
- bus_wen  out  1  write strobe, one cycle
- bus_rdata  in  DATA_W  memory read data, sampled when bus_busy low in WAIT
- bus_busy  in  1  memory operation in progress
- stall  out  1  freeze PC/datapath
- bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE, timeout counter=0.
  - All outputs 0: i_rdata, d_rdata, bus_addr, bus_wdata, bus_sel, bus_ren, bus_wen, i_ready, d_ready, bus_err.
  - Reset mid-access drops the in-flight transaction; no ready pulse is issued. Requesters re-assert.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any request is high at posedge, latch the grant, address, wdata and sel. Next state is ISSUE.
  - Priority: data over fetch (current instruction completes before next fetch).
  - d_write_req and d_read_req both high: write wins; the read is ignored for that grant.
- ISSUE: bus_addr/bus_wdata/bus_sel hold the latched values. Exactly one of bus_ren/bus_wen high for this single cycle. Next state is WAIT.
- WAIT:
  - Address, data and sel stay stable; strobes are low.
  - bus_busy low at posedge: capture bus_rdata into the granted rdata register (writes leave d_rdata unchanged). Next state is DONE.
  - bus_busy high: increment the counter. When the counter reaches TIMEOUT-1, abort: set bus_err (sticky until rst), load rdata with 0, go to DONE.
- DONE:
  - Granted ready=1 for exactly this cycle; the other ready stays 0. Counter cleared. Next state is IDLE.
  - Requesters must deassert req by the posedge ending DONE; a req still high in IDLE is treated as a new access.
- Latency: req high in IDLE cycle 0 → ISSUE cycle 1 → WAIT cycle 2 → ready in cycle 3 when busy is low at the first WAIT sample. Each extra busy cycle adds one cycle.
- stall = (i_read_req | d_read_req | d_write_req) & ~(i_ready | d_ready), combinational. It is low in the DONE cycle so the PC advances exactly once.
- Back-to-back: no fetch is granted while a data request is high. After a data DONE, the pending fetch is granted in the following IDLE cycle.
- All outputs except stall are registered.

Test Plan:
- Fetch only: i_read_req=1, i_addr=0x0000_0004, busy held 0, bus_rdata=0x3e800093 → bus_ren=1 with bus_sel=4'hF in cycle 1; i_ready=1, i_rdata=0x3e800093 in cycle 3; stall low only in cycle 3.
- Store with wait states: d_write_req=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_sel=4'b0011, busy high 3 cycles → bus_wen one cycle, bus_addr/wdata/sel stable through WAIT; d_ready in cycle 6; d_rdata unchanged.
- Simultaneous requests: i_read_req=1 and d_read_req=1 in the same cycle, d_addr=0x200 → data granted first (bus_addr=0x200), d_ready pulses; fetch bus_ren follows on the next IDLE, with i_ready 4 cycles after d_ready.
- Timeout: TIMEOUT=16, d_read_req=1, busy stuck high → d_ready pulses with d_rdata=0 after 16 WAIT cycles; bus_err=1 and stays 1 for later successful accesses until rst.
- Reset mid-access: assert rst during WAIT → next cycle state IDLE, all outputs 0, no ready pulse; a re-asserted request completes normally.
- Read+write conflict: d_read_req=d_write_req=1 → only bus_wen strobes, never bus_ren.
